// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: FSM encodings
// and stage indices used to address per-stage stall/flush vectors.
package pipe_ctrl_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_RUN   = 2'b00,
    ST_DRAIN = 2'b01,
    ST_FLUSH = 2'b10
  } ctrl_state_e;

  localparam int STAGE_F = 0;
  localparam int STAGE_D = 1;
  localparam int STAGE_E = 2;
  localparam int STAGE_M = 3;
  localparam int STAGE_W = 4;
  localparam int NUM_STAGES = 5;

endpackage

// File: rtl/flopr.sv
// Resettable flip-flop bank; asynchronous active-high reset to zero.
module flopr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= d;
  end

endmodule

// File: rtl/stall_counter.sv
// Free-running stall-cycle counter; wraps naturally at its width.
module stall_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencing for the 5-stage core; exception flushes wait for
// outstanding sram-like transactions. Stall counter built only with PIPE_STALL_CNT_EN.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_busy,
  input  logic             data_busy,
  input  logic             div_busy,
  input  logic             lw_hazard_d,
  input  logic             excep_m,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             stall_w,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_m,
  output logic             flush_w,
  output logic             redirect_f,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [ST_W-1:0]            state_q;
  ctrl_state_e                state_d;
  logic                       mem_busy;
  logic                       flush_ev;
  logic [NUM_STAGES-1:0]      stall_v;
  logic [STAGE_W:STAGE_D]     flush_v;
  logic                       redirect;

  flopr #(.WIDTH(ST_W)) u_state (
    .clk (clk),
    .rst (rst),
    .d   (state_d),
    .q   (state_q)
  );

  always_comb begin
    mem_busy = inst_busy | data_busy;
    state_d  = ST_RUN;
    stall_v  = '0;
    flush_v  = '0;
    redirect = 1'b0;

    // 2'b11 falls to default and recovers to RUN
    case (state_q)
      ST_RUN:   if (excep_m && mem_busy) state_d = ST_DRAIN;
      ST_DRAIN: state_d = mem_busy ? ST_DRAIN : ST_FLUSH;
      default:  state_d = ST_RUN;
    endcase

    flush_ev = (state_q == ST_FLUSH) ||
               ((state_q == ST_RUN) && excep_m && !mem_busy);

    // Priority chain keeps any flushed register from also being stalled
    if (flush_ev) begin
      flush_v  = '1;
      redirect = 1'b1;
    end else if ((state_q == ST_DRAIN) || mem_busy) begin
      stall_v = '1;
    end else if (div_busy) begin
      stall_v[STAGE_F] = 1'b1;
      stall_v[STAGE_D] = 1'b1;
      stall_v[STAGE_E] = 1'b1;
      flush_v[STAGE_M] = 1'b1;
    end else if (lw_hazard_d) begin
      stall_v[STAGE_F] = 1'b1;
      stall_v[STAGE_D] = 1'b1;
      flush_v[STAGE_E] = 1'b1;
    end
  end

  assign stall_f    = stall_v[STAGE_F] & ~rst;
  assign stall_d    = stall_v[STAGE_D] & ~rst;
  assign stall_e    = stall_v[STAGE_E] & ~rst;
  assign stall_m    = stall_v[STAGE_M] & ~rst;
  assign stall_w    = stall_v[STAGE_W] & ~rst;
  assign flush_d    = flush_v[STAGE_D] & ~rst;
  assign flush_e    = flush_v[STAGE_E] & ~rst;
  assign flush_m    = flush_v[STAGE_M] & ~rst;
  assign flush_w    = flush_v[STAGE_W] & ~rst;
  assign redirect_f = redirect & ~rst;
  assign ctrl_state = state_q;

`ifdef PIPE_STALL_CNT_EN
  stall_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_f),
    .cnt (stall_cnt)
  );
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed scenarios plus randomized traffic
// against a pending-exception reference model.
module tb_pipe_stall_ctrl;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst;
  logic inst_busy, data_busy, div_busy, lw_hazard_d, excep_m;
  logic stall_f, stall_d, stall_e, stall_m, stall_w;
  logic flush_d, flush_e, flush_m, flush_w, redirect_f;
  logic [1:0] ctrl_state;
  logic [CNT_W-1:0] stall_cnt;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .inst_busy(inst_busy), .data_busy(data_busy), .div_busy(div_busy),
    .lw_hazard_d(lw_hazard_d), .excep_m(excep_m),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
    .stall_m(stall_m), .stall_w(stall_w),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
    .redirect_f(redirect_f), .ctrl_state(ctrl_state), .stall_cnt(stall_cnt)
  );

  // {stall_f,d,e,m,w, flush_d,e,m,w, redirect_f}
  wire [9:0] outs = {stall_f, stall_d, stall_e, stall_m, stall_w,
                     flush_d, flush_e, flush_m, flush_w, redirect_f};

  localparam logic [9:0] O_IDLE  = 10'b00000_0000_0;
  localparam logic [9:0] O_LW    = 10'b11000_0100_0;
  localparam logic [9:0] O_DIV   = 10'b11100_0010_0;
  localparam logic [9:0] O_STALL = 10'b11111_0000_0;
  localparam logic [9:0] O_FLUSH = 10'b00000_1111_1;

  // Reference model: an exception is either waiting for memory or has a flush queued.
  bit m_waiting, m_flush_next;
  logic [CNT_W-1:0] m_cnt;

  function automatic logic [9:0] model_outs();
    bit mem = inst_busy | data_busy;
    if (rst) return O_IDLE;
    if (m_flush_next || (!m_waiting && excep_m && !mem)) return O_FLUSH;
    if (m_waiting || mem) return O_STALL;
    if (div_busy) return O_DIV;
    if (lw_hazard_d) return O_LW;
    return O_IDLE;
  endfunction

  function automatic logic [1:0] model_state();
    if (m_flush_next) return 2'd2;
    if (m_waiting) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [CNT_W-1:0] model_cnt();
`ifdef PIPE_STALL_CNT_EN
    return m_cnt;
`else
    return '0;
`endif
  endfunction

  task automatic set_in(input bit ib, input bit db, input bit dv, input bit lw, input bit ex);
    inst_busy = ib; data_busy = db; div_busy = dv; lw_hazard_d = lw; excep_m = ex;
  endtask

  // Advance one clock, update the model with the inputs that were live at the edge.
  task automatic tick();
    logic [9:0] o = model_outs();
    bit mem = inst_busy | data_busy;
    @(posedge clk);
    if (rst) begin
      m_waiting = 0; m_flush_next = 0; m_cnt = '0;
    end else begin
      if (o[9]) m_cnt = m_cnt + 1'b1;
      if (m_flush_next) m_flush_next = 0;
      else if (m_waiting) begin
        if (!mem) begin m_waiting = 0; m_flush_next = 1; end
      end else if (excep_m && mem) m_waiting = 1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    set_in(1, 1, 1, 1, 1);
    rst = 1'b1;
    m_waiting = 0; m_flush_next = 0; m_cnt = '0;
    #1;
    n_chk++; if (outs !== O_IDLE) $display("FAIL reset_outs got=%b exp=%b", outs, O_IDLE); else n_pass++;
    n_chk++; if (ctrl_state !== 2'd0) $display("FAIL reset_state got=%0d exp=0", ctrl_state); else n_pass++;
    n_chk++; if (stall_cnt !== '0) $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); else n_pass++;
    tick(); tick();
    set_in(0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    n_chk++; if (outs !== O_IDLE) $display("FAIL post_reset_outs got=%b exp=%b", outs, O_IDLE); else n_pass++;
    tick();
  endtask

  task automatic test_load_use();
    logic [CNT_W-1:0] c0 = model_cnt();
    set_in(0, 0, 0, 1, 0); #1;
    n_chk++; if (outs !== O_LW) $display("FAIL load_use_outs got=%b exp=%b", outs, O_LW); else n_pass++;
    tick();
    set_in(0, 0, 0, 0, 0); #1;
`ifdef PIPE_STALL_CNT_EN
    n_chk++; if (stall_cnt !== c0 + 1) $display("FAIL load_use_cnt got=%0d exp=%0d", stall_cnt, c0 + 1); else n_pass++;
`else
    n_chk++; if (stall_cnt !== '0) $display("FAIL load_use_cnt got=%0d exp=0 c0=%0d", stall_cnt, c0); else n_pass++;
`endif
    tick();
  endtask

  task automatic test_divider();
    set_in(0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_chk++; if (outs !== O_DIV) $display("FAIL div_outs cyc=%0d got=%b exp=%b", i, outs, O_DIV); else n_pass++;
      tick();
    end
    set_in(0, 0, 0, 0, 0); #1;
    n_chk++; if (stall_cnt !== model_cnt()) $display("FAIL div_cnt got=%0d exp=%0d", stall_cnt, model_cnt()); else n_pass++;
  endtask

  task automatic test_mem_over_div();
    set_in(0, 1, 1, 1, 0); #1;
    n_chk++; if (outs !== O_STALL) $display("FAIL mem_over_div got=%b exp=%b", outs, O_STALL); else n_pass++;
    tick();
    set_in(0, 0, 0, 0, 0); #1;
    tick();
  endtask

  task automatic test_excep_idle();
    set_in(0, 0, 1, 1, 1); #1;
    n_chk++; if (outs !== O_FLUSH) $display("FAIL excep_idle_outs got=%b exp=%b", outs, O_FLUSH); else n_pass++;
    n_chk++; if (ctrl_state !== 2'd0) $display("FAIL excep_idle_state got=%0d exp=0", ctrl_state); else n_pass++;
    tick();
    set_in(0, 0, 0, 0, 0); #1;
    n_chk++; if (ctrl_state !== 2'd0) $display("FAIL excep_idle_after got=%0d exp=0", ctrl_state); else n_pass++;
    tick();
  endtask

  task automatic test_excep_busy();
    set_in(1, 0, 0, 0, 1); #1;
    n_chk++; if (outs !== O_STALL) $display("FAIL exb_first got=%b exp=%b", outs, O_STALL); else n_pass++;
    tick();
    // three DRAIN cycles; memory stays busy for two, excep_m toggles freely
    for (int i = 0; i < 3; i++) begin
      set_in(i < 2, 0, i == 1, 1, i[0]); #1;
      n_chk++; if (ctrl_state !== 2'd1) $display("FAIL exb_drain_state cyc=%0d got=%0d exp=1", i, ctrl_state); else n_pass++;
      n_chk++; if (outs !== O_STALL) $display("FAIL exb_drain_outs cyc=%0d got=%b exp=%b", i, outs, O_STALL); else n_pass++;
      tick();
    end
    set_in(0, 0, 0, 0, 1); #1;
    n_chk++; if (ctrl_state !== 2'd2) $display("FAIL exb_flush_state got=%0d exp=2", ctrl_state); else n_pass++;
    n_chk++; if (outs !== O_FLUSH) $display("FAIL exb_flush_outs got=%b exp=%b", outs, O_FLUSH); else n_pass++;
    tick();
    set_in(0, 0, 0, 0, 0); #1;
    n_chk++; if (ctrl_state !== 2'd0) $display("FAIL exb_run_state got=%0d exp=0", ctrl_state); else n_pass++;
    n_chk++; if (outs !== O_IDLE) $display("FAIL exb_run_outs got=%b exp=%b", outs, O_IDLE); else n_pass++;
    tick();
  endtask

  task automatic test_drop_and_excep();
    set_in(0, 1, 0, 0, 0); #1;
    tick();
    set_in(0, 0, 0, 0, 1); #1;
    n_chk++; if (outs !== O_FLUSH) $display("FAIL drop_excep_outs got=%b exp=%b", outs, O_FLUSH); else n_pass++;
    tick();
    set_in(0, 0, 0, 0, 0); #1;
    n_chk++; if (ctrl_state !== 2'd0) $display("FAIL drop_excep_state got=%0d exp=0", ctrl_state); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_drain();
    set_in(0, 1, 0, 0, 1); #1;
    tick();
    set_in(0, 1, 0, 0, 0); #1;
    n_chk++; if (ctrl_state !== 2'd1) $display("FAIL rmd_drain got=%0d exp=1", ctrl_state); else n_pass++;
    set_in(0, 0, 0, 0, 0);
    rst = 1'b1;
    m_waiting = 0; m_flush_next = 0; m_cnt = '0;
    #1;
    n_chk++; if (outs !== O_IDLE) $display("FAIL rmd_outs got=%b exp=%b", outs, O_IDLE); else n_pass++;
    n_chk++; if (ctrl_state !== 2'd0) $display("FAIL rmd_state got=%0d exp=0", ctrl_state); else n_pass++;
    n_chk++; if (stall_cnt !== '0) $display("FAIL rmd_cnt got=%0d exp=0", stall_cnt); else n_pass++;
    tick();
    rst = 1'b0; #1;
    for (int i = 0; i < 2; i++) begin
      n_chk++; if (ctrl_state !== 2'd0 || outs !== O_IDLE)
        $display("FAIL rmd_no_flush cyc=%0d state=%0d outs=%b exp state=0 outs=%b", i, ctrl_state, outs, O_IDLE);
      else n_pass++;
      tick(); #1;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0);
      #1;
      n_chk++; if (outs !== model_outs()) $display("FAIL rnd_outs cyc=%0d got=%b exp=%b", i, outs, model_outs()); else n_pass++;
      n_chk++; if (ctrl_state !== model_state()) $display("FAIL rnd_state cyc=%0d got=%0d exp=%0d", i, ctrl_state, model_state()); else n_pass++;
      n_chk++; if (stall_cnt !== model_cnt()) $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", i, stall_cnt, model_cnt()); else n_pass++;
      tick();
    end
    set_in(0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0);
    @(negedge clk);
    test_reset();
    test_load_use();
    test_divider();
    test_mem_over_div();
    test_excep_idle();
    test_excep_busy();
    test_drop_and_excep();
    test_reset_mid_drain();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
